// File: rtl/module_display_scan_pkg.sv
// Shared constants and types for the multiplexed seven-segment display scanner.
package display_pkg;

    localparam int N_DIGITS = 8;
    localparam int NIBBLE_W = 4;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam seg_t SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/module_display_scan_if.sv
// Data/strobe inputs and display outputs of the scanner, bundled for the host and the scanner.
interface module_display_scan_if;
    import display_pkg::*;

    logic [N_DIGITS*NIBBLE_W-1:0] data_i;
    logic                         load_i;
    logic [N_DIGITS-1:0]          dp_i;
    logic                         en_i;
    logic [N_DIGITS-1:0]          an_o;
    seg_t                         seg_o;
    logic                         dp_o;
    logic                         frame_done_o;

    modport master (
        output data_i, load_i, dp_i, en_i,
        input  an_o, seg_o, dp_o, frame_done_o
    );

    modport slave (
        input  data_i, load_i, dp_i, en_i,
        output an_o, seg_o, dp_o, frame_done_o
    );

endinterface

// File: rtl/module_display_scan_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module module_hex_to_7seg
    import display_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_nibble,
    output seg_t                o_seg
);

    assign o_seg = SEG_LUT[i_nibble];

endmodule

// File: rtl/module_display_scan.sv
// 8-digit multiplexed seven-segment scanner with frame-boundary double buffering,
// per-slot anode guard gap and optional leading-zero blanking.
module module_display_scan
    import display_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 10_000_000,
    parameter int DIGIT_HZ     = 1_000,
    parameter int GUARD_CYCLES = 16,
    parameter int BLANK_LZ     = 1
)
(
    input  logic                 clk_10Mhz_i,
    input  logic                 rst_i,
    module_display_scan_if.slave bus
);

    localparam int TICKS_PER_DIGIT = CLK_FREQ_HZ / DIGIT_HZ;
    localparam int TW     = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam int IW     = $clog2(N_DIGITS);
    localparam int WORD_W = N_DIGITS * NIBBLE_W;

    logic [TW-1:0]       r_tick;
    logic [IW-1:0]       r_idx;
    logic [WORD_W-1:0]   r_staging;
    logic [WORD_W-1:0]   r_shadow;
    logic [N_DIGITS-1:0] r_dp_staging;
    logic [N_DIGITS-1:0] r_dp_shadow;
    logic                r_pending;
    logic [N_DIGITS-1:0] r_an;
    seg_t                r_seg;
    logic                r_dp;

    logic                w_tc;
    logic                w_wrap;
    logic                w_guard;
    logic                w_blank;
    logic [N_DIGITS-1:0] w_upper_zero;
    logic [NIBBLE_W-1:0] w_nibble;
    seg_t                w_seg;

    assign w_tc    = (r_tick == TW'(TICKS_PER_DIGIT - 1));
    assign w_wrap  = w_tc && (r_idx == IW'(N_DIGITS - 1));
    assign w_guard = (r_tick < TW'(GUARD_CYCLES));

    // w_upper_zero[gi]: every nibble from digit gi up to the leftmost digit is zero
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_upper_zero
            assign w_upper_zero[gi] = ~|r_shadow[WORD_W-1:gi*NIBBLE_W];
        end
    endgenerate

    assign w_blank  = (BLANK_LZ != 0) && (r_idx != '0) && w_upper_zero[r_idx] && !r_dp_shadow[r_idx];
    assign w_nibble = r_shadow[r_idx*NIBBLE_W +: NIBBLE_W];

    module_hex_to_7seg u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk_10Mhz_i or posedge rst_i) begin
        if (rst_i) begin
            r_tick <= '0;
            r_idx  <= '0;
        end else if (w_tc) begin
            r_tick <= '0;
            r_idx  <= r_idx + 1'b1;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    // A load landing on the wrap cycle bypasses staging so it is shown in the very next frame.
    always_ff @(posedge clk_10Mhz_i or posedge rst_i) begin
        if (rst_i) begin
            r_staging    <= '0;
            r_dp_staging <= '0;
            r_shadow     <= '0;
            r_dp_shadow  <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (bus.load_i) begin
                r_staging    <= bus.data_i;
                r_dp_staging <= bus.dp_i;
            end
            if (w_wrap) begin
                if (bus.load_i) begin
                    r_shadow    <= bus.data_i;
                    r_dp_shadow <= bus.dp_i;
                end else if (r_pending) begin
                    r_shadow    <= r_staging;
                    r_dp_shadow <= r_dp_staging;
                end
                r_pending <= 1'b0;
            end else if (bus.load_i) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_10Mhz_i or posedge rst_i) begin
        if (rst_i) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (!w_guard && bus.en_i && !w_blank) begin
            r_an  <= ~({{(N_DIGITS-1){1'b0}}, 1'b1} << r_idx);
            r_seg <= w_seg;
            r_dp  <= ~r_dp_shadow[r_idx];
        end else begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end
    end

    assign bus.an_o         = r_an;
    assign bus.seg_o        = r_seg;
    assign bus.dp_o         = r_dp;
    assign bus.frame_done_o = w_wrap;

endmodule

// File: tb/tb_module_display_scan.sv
// Randomized + directed bench for module_display_scan with a cycle-indexed reference model and scoreboard.
module tb_module_display_scan;

    localparam int TPD   = 8;
    localparam int GUARD = 2;
    localparam int FRAME = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    module_display_scan_if bus ();

    module_display_scan #(
        .CLK_FREQ_HZ  (80),
        .DIGIT_HZ     (10),
        .GUARD_CYCLES (GUARD),
        .BLANK_LZ     (1)
    ) dut (
        .clk_10Mhz_i (clk),
        .rst_i       (rst),
        .bus         (bus)
    );

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        bit         seg_care;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 0;

    logic [6:0] ref_lut [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Model state: cycle count since reset release and the displayed/queued words
    int          cyc;
    logic [31:0] m_shadow, m_staging;
    logic [7:0]  m_dps, m_dp_staging;
    bit          m_pending;
    bit          cur_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", name, c, act, req);
    endtask

    // Expected outputs in cycle c+1, from the displayed word and the slot timing of cycle c
    function automatic exp_t model_out(input int c, input bit en);
        exp_t        e;
        int          tick = c % TPD;
        int          slot = (c / TPD) % 8;
        logic [31:0] upper = m_shadow >> (4 * slot);
        logic [3:0]  nib = upper[3:0];
        bit          lit;
        e.cyc = c + 1;
        e.fd  = ((c + 1) % FRAME) == (FRAME - 1);
        e.seg_care = (tick >= GUARD);
        lit = (tick >= GUARD) && en && (slot == 0 || upper != 0 || m_dps[slot]);
        if (lit) begin
            e.an  = ~(8'd1 << slot);
            e.seg = ref_lut[nib];
            e.dp  = ~m_dps[slot];
        end else begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end
        return e;
    endfunction

    task automatic step(input bit ld, input logic [31:0] d, input logic [7:0] dp);
        bit wrap = (cyc % FRAME) == (FRAME - 1);
        bus.load_i = ld;
        bus.data_i = d;
        bus.dp_i   = dp;
        bus.en_i   = cur_en;
        sb_q.push_back(model_out(cyc, cur_en));
        if (ld && wrap) begin
            m_shadow = d; m_dps = dp; m_pending = 0;
        end else if (ld) begin
            m_staging = d; m_dp_staging = dp; m_pending = 1;
        end else if (wrap && m_pending) begin
            m_shadow = m_staging; m_dps = m_dp_staging; m_pending = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 8'h00);
    endtask

    task automatic run_to_wrap();
        for (int i = 0; i < FRAME && (cyc % FRAME) != (FRAME - 1); i++) idle(1);
    endtask

    task automatic do_reset();
        exp_t e;
        mon_en = 0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        bus.load_i = 1'b0;
        #1;
        check("rst_an",  32'(bus.an_o),         32'hFF, -1);
        check("rst_seg", 32'(bus.seg_o),        32'h7F, -1);
        check("rst_dp",  32'(bus.dp_o),         32'h1,  -1);
        check("rst_fd",  32'(bus.frame_done_o), 32'h0,  -1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        m_shadow = '0; m_staging = '0; m_dps = '0; m_dp_staging = '0; m_pending = 0;
        sb_q.delete();
        e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0; e.seg_care = 1; e.cyc = 0;
        sb_q.push_back(e);
        mon_en = 1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL sb_empty actual=no_entry required=entry");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("an", 32'(bus.an_o),         32'(e.an), e.cyc);
                check("fd", 32'(bus.frame_done_o), 32'(e.fd), e.cyc);
                if (e.seg_care) begin
                    check("seg", 32'(bus.seg_o), 32'(e.seg), e.cyc);
                    check("dp",  32'(bus.dp_o),  32'(e.dp),  e.cyc);
                end
            end
        end
    end

    initial begin
        logic [31:0] d, mask;
        int          keep;
        bus.load_i = 1'b0; bus.data_i = '0; bus.dp_i = '0; bus.en_i = 1'b1;
        cur_en = 1;
        rst = 1'b1;
        #12;
        rst = 1'b0;
        do_reset();
        idle(70);

        // Double buffer: mid-frame load held until the wrap
        while ((cyc % FRAME) != 20) idle(1);
        step(1'b1, 32'h1234_5678, 8'h00);
        idle(140);

        step(1'b1, 32'h0000_00AD, 8'h00);
        idle(130);
        step(1'b1, 32'hDEBE_BEBE, 8'h00);
        idle(130);

        // Load on the wrap cycle, then a second load one cycle later
        run_to_wrap();
        step(1'b1, 32'hBEEF_0001, 8'h00);
        step(1'b1, 32'h0000_0002, 8'h00);
        idle(140);

        cur_en = 0;
        idle(80);
        cur_en = 1;
        idle(70);

        step(1'b1, 32'h0000_0000, 8'h04);
        idle(130);

        // Async reset with a pending, non-zero word must clear everything
        step(1'b1, 32'hCAFE_F00D, 8'hFF);
        idle(5);
        do_reset();
        idle(70);

        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 49) == 0) cur_en = ~cur_en;
            if ($urandom_range(0, 19) == 0) begin
                keep = $urandom_range(0, 8);
                mask = (keep == 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * keep)) - 32'h1);
                d = $urandom & mask;
                step(1'b1, d, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
            end else begin
                idle(1);
            end
        end
        cur_en = 1;
        idle(10);

        @(negedge clk);
        #1;
        mon_en = 0;
        check("sb_drained", 32'(sb_q.size()), 32'h0, cyc);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
